// File: rtl/dmem_wb_if_if.sv
// Wishbone B3 classic bus bundle between the data-memory bridge (master) and the slave.
// Parameter widths must match the bridge instance that drives it.
interface dmem_wb_if_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   wb_adr_o;
  logic [DATA_W-1:0]   wb_dat_o;
  logic [DATA_W-1:0]   wb_dat_i;
  logic                wb_we_o;
  logic [DATA_W/8-1:0] wb_sel_o;
  logic                wb_stb_o;
  logic                wb_cyc_o;
  logic                wb_ack_i;

  modport master (
    output wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    input  wb_adr_o, wb_dat_o, wb_we_o, wb_sel_o, wb_stb_o, wb_cyc_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/dmem_wb_if.sv
// MEM-stage data-RAM port to Wishbone B3 classic master; stalls the core until the slave acks.
// Optional BUSY timeout abort is compiled in when DMEM_WB_TIMEOUT_EN is defined.
module dmem_wb_if #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [5:0]          stall_i,
  input  logic                flush_i,
  input  logic                cpu_ce_i,
  input  logic                cpu_we_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W-1:0]   cpu_data_i,
  input  logic [DATA_W/8-1:0] cpu_sel_i,
  output logic [DATA_W-1:0]   cpu_data_o,
  output logic                stallreq_o,
  output logic                bus_err_o,
  dmem_wb_if_if.master        wb
);

  localparam int SEL_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    BUSY       = 2'd1,
    WAIT_STALL = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                cyc_q, cyc_d;
  logic [ADDR_W-1:0]   adr_q, adr_d;
  logic [DATA_W-1:0]   dat_q, dat_d;
  logic                we_q, we_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   rd_buf_q, rd_buf_d;

  logic mem_held;
  logic issue;
  logic ack;
  logic timeout_hit;
  logic done;

  assign mem_held = stall_i[4];
  assign issue    = cpu_ce_i & ~flush_i;
  assign ack      = wb.wb_ack_i;
  assign done     = ack | timeout_hit;

  logic unused_stall;
  assign unused_stall = ^{stall_i[5], stall_i[3:0]};

`ifdef DMEM_WB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q;

  // A flush in the same cycle abandons the access, so it never reports an error.
  assign timeout_hit = (state_q == BUSY) & ~ack & ~flush_i &
                       (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && issue) begin
      cnt_d = '0;
    end else if (state_q == BUSY && !done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= timeout_hit;
    end
  end

  assign bus_err_o = err_q;
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;

  assign timeout_hit = 1'b0;
  assign bus_err_o   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cyc_q    <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      rd_buf_q <= '0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      adr_q    <= adr_d;
      dat_q    <= dat_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      rd_buf_q <= rd_buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (issue) state_d = BUSY;
      end
      BUSY: begin
        if (flush_i)   state_d = IDLE;
        else if (done) state_d = mem_held ? WAIT_STALL : IDLE;
      end
      WAIT_STALL: begin
        if (flush_i || !mem_held) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus attributes are captured only at issue, so they stay frozen for the whole cycle.
  always_comb begin
    cyc_d    = cyc_q;
    adr_d    = adr_q;
    dat_d    = dat_q;
    we_d     = we_q;
    sel_d    = sel_q;
    rd_buf_d = rd_buf_q;
    case (state_q)
      IDLE: begin
        if (issue) begin
          cyc_d = 1'b1;
          adr_d = cpu_addr_i;
          dat_d = cpu_data_i;
          we_d  = cpu_we_i;
          sel_d = cpu_sel_i;
        end
      end
      BUSY: begin
        if (flush_i || done) cyc_d = 1'b0;
        if (!flush_i && done) rd_buf_d = (ack && !we_q) ? wb.wb_dat_i : '0;
      end
      default: ;
    endcase
  end

  always_comb begin
    stallreq_o = 1'b0;
    cpu_data_o = '0;
    case (state_q)
      IDLE: begin
        stallreq_o = issue;
      end
      BUSY: begin
        stallreq_o = ~done;
        if (ack && !flush_i && !we_q) cpu_data_o = wb.wb_dat_i;
      end
      WAIT_STALL: begin
        cpu_data_o = rd_buf_q;
      end
      default: ;
    endcase
  end

  assign wb.wb_cyc_o = cyc_q;
  assign wb.wb_stb_o = cyc_q;
  assign wb.wb_adr_o = adr_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_we_o  = we_q;
  assign wb.wb_sel_o = sel_q;

endmodule

// File: tb/tb_dmem_wb_if.sv
// Bench for dmem_wb_if: directed vector table, timeout sequence (when enabled) and
// randomized traffic compared cycle by cycle against a transaction-level model.
module tb_dmem_wb_if;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
`ifdef DMEM_WB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic        cpu_ce_i;
  logic        cpu_we_i;
  logic [31:0] cpu_addr_i;
  logic [31:0] cpu_data_i;
  logic [3:0]  cpu_sel_i;
  logic [31:0] cpu_data_o;
  logic        stallreq_o;
  logic        bus_err_o;

  always #5 clk = ~clk;

  dmem_wb_if_if #(.ADDR_W(AW), .DATA_W(DW)) wb_bus ();

  dmem_wb_if #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .flush_i    (flush_i),
    .cpu_ce_i   (cpu_ce_i),
    .cpu_we_i   (cpu_we_i),
    .cpu_addr_i (cpu_addr_i),
    .cpu_data_i (cpu_data_i),
    .cpu_sel_i  (cpu_sel_i),
    .cpu_data_o (cpu_data_o),
    .stallreq_o (stallreq_o),
    .bus_err_o  (bus_err_o),
    .wb         (wb_bus)
  );

  typedef struct {
    bit          rst;
    bit          st4;
    bit          flush;
    bit          ce;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    bit          ack;
    logic [31:0] rdat;
  } in_t;

  typedef struct {
    in_t         i;
    bit          e_stall;
    logic [31:0] e_data;
    bit          e_cyc;
  } vec_t;

  int n_chk  = 0;
  int n_pass = 0;

  // Transaction-level model: an outstanding access, or held load data awaiting the pipeline.
  bit          m_pend;
  bit          m_hold;
  logic [31:0] m_buf;
  logic [31:0] m_adr;
  logic [31:0] m_dat;
  bit          m_we;
  logic [3:0]  m_sel;
  bit          m_err;
  int          m_waits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic in_t mk_in(bit r, bit s4, bit fl, bit ce, bit we, logic [31:0] a,
                                logic [31:0] wd, logic [3:0] sl, bit ak, logic [31:0] rd);
    in_t v;
    v.rst = r; v.st4 = s4; v.flush = fl; v.ce = ce; v.we = we;
    v.addr = a; v.wdat = wd; v.sel = sl; v.ack = ak; v.rdat = rd;
    return v;
  endfunction

  function automatic vec_t mk(in_t v, bit es, logic [31:0] ed, bit ec);
    vec_t t;
    t.i = v; t.e_stall = es; t.e_data = ed; t.e_cyc = ec;
    return t;
  endfunction

  function automatic bit timed_out(in_t v);
    return TO_EN && m_pend && !v.ack && !v.flush && (m_waits + 1 == TO);
  endfunction

  task automatic model_check(in_t v);
    bit          to_hit;
    bit          done;
    bit          e_stall;
    logic [31:0] e_data;
    to_hit = timed_out(v);
    done   = m_pend && (v.ack || to_hit);
    if (m_pend)      e_stall = !done;
    else if (m_hold) e_stall = 1'b0;
    else             e_stall = v.ce && !v.flush;
    if (m_pend)      e_data = (v.ack && !v.flush && !m_we) ? v.rdat : 32'h0;
    else if (m_hold) e_data = m_buf;
    else             e_data = 32'h0;
    chk("m_stallreq", 32'(stallreq_o), 32'(e_stall));
    chk("m_cpu_data", cpu_data_o, e_data);
    chk("m_cyc", 32'(wb_bus.wb_cyc_o), 32'(m_pend));
    chk("m_stb", 32'(wb_bus.wb_stb_o), 32'(m_pend));
    chk("m_adr", wb_bus.wb_adr_o, m_adr);
    chk("m_dat", wb_bus.wb_dat_o, m_dat);
    chk("m_we", 32'(wb_bus.wb_we_o), 32'(m_we));
    chk("m_sel", 32'(wb_bus.wb_sel_o), 32'(m_sel));
    chk("m_bus_err", 32'(bus_err_o), 32'(m_err));
  endtask

  task automatic model_update(in_t v);
    bit to_hit;
    to_hit = timed_out(v);
    if (v.rst) begin
      m_pend = 0; m_hold = 0; m_buf = 0; m_adr = 0; m_dat = 0;
      m_we = 0; m_sel = 0; m_err = 0; m_waits = 0;
    end else begin
      m_err = to_hit;
      if (m_pend) begin
        if (v.flush) begin
          m_pend = 0;
        end else if (v.ack || to_hit) begin
          m_pend = 0;
          m_buf  = (v.ack && !m_we) ? v.rdat : 32'h0;
          m_hold = v.st4;
        end else begin
          m_waits++;
        end
      end else if (m_hold) begin
        if (v.flush || !v.st4) m_hold = 0;
      end else if (v.ce && !v.flush) begin
        m_pend = 1; m_adr = v.addr; m_dat = v.wdat; m_we = v.we; m_sel = v.sel; m_waits = 0;
      end
    end
  endtask

  task automatic drive(in_t v, bit do_chk, logic [5:0] other_stall);
    @(negedge clk);
    rst        = v.rst;
    stall_i    = {other_stall[5], v.st4, other_stall[3:0]};
    flush_i    = v.flush;
    cpu_ce_i   = v.ce;
    cpu_we_i   = v.we;
    cpu_addr_i = v.addr;
    cpu_data_i = v.wdat;
    cpu_sel_i  = v.sel;
    wb_bus.wb_ack_i = v.ack;
    wb_bus.wb_dat_i = v.rdat;
    #1;
    if (do_chk) model_check(v);
  endtask

  task automatic advance(in_t v);
    @(posedge clk);
    model_update(v);
  endtask

  vec_t tbl[$];
  in_t  idle_v;
  in_t  rst_v;

  initial begin
    idle_v = mk_in(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);
    rst_v  = mk_in(1, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0);

    // Reset state
    tbl.push_back(mk(idle_v, 0, 32'h0, 0));
    // Zero-wait load from 0x100
    tbl.push_back(mk(mk_in(0, 0, 0, 1, 0, 32'h100, 32'h0, 4'hF, 0, 32'h0), 1, 32'h0, 0));
    tbl.push_back(mk(mk_in(0, 0, 0, 1, 0, 32'h100, 32'h0, 4'hF, 1, 32'hDEADBEEF), 0, 32'hDEADBEEF, 1));
    tbl.push_back(mk(idle_v, 0, 32'h0, 0));
    // Store with three wait states
    tbl.push_back(mk(mk_in(0, 0, 0, 1, 1, 32'h200, 32'h1234, 4'h3, 0, 32'h0), 1, 32'h0, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(mk_in(0, 0, 0, 1, 1, 32'h200, 32'h1234, 4'h3, 0, 32'h55555555), 1, 32'h0, 1));
    tbl.push_back(mk(mk_in(0, 0, 0, 1, 1, 32'h200, 32'h1234, 4'h3, 1, 32'h77777777), 0, 32'h0, 1));
    tbl.push_back(mk(idle_v, 0, 32'h0, 0));
    // Ack while MEM is held for two cycles
    tbl.push_back(mk(mk_in(0, 0, 0, 1, 0, 32'h300, 32'h0, 4'hF, 0, 32'h0), 1, 32'h0, 0));
    tbl.push_back(mk(mk_in(0, 1, 0, 1, 0, 32'h300, 32'h0, 4'hF, 1, 32'hCAFEF00D), 0, 32'hCAFEF00D, 1));
    tbl.push_back(mk(mk_in(0, 1, 0, 1, 0, 32'h300, 32'h0, 4'hF, 0, 32'h0), 0, 32'hCAFEF00D, 0));
    tbl.push_back(mk(mk_in(0, 0, 0, 1, 0, 32'h300, 32'h0, 4'hF, 0, 32'h0), 0, 32'hCAFEF00D, 0));
    tbl.push_back(mk(idle_v, 0, 32'h0, 0));
    // Flush coincident with ack
    tbl.push_back(mk(mk_in(0, 0, 0, 1, 0, 32'h400, 32'h0, 4'hF, 0, 32'h0), 1, 32'h0, 0));
    tbl.push_back(mk(mk_in(0, 0, 1, 1, 0, 32'h400, 32'h0, 4'hF, 1, 32'h11111111), 0, 32'h0, 1));
    tbl.push_back(mk(idle_v, 0, 32'h0, 0));
    // Reset during BUSY, then a late ack
    tbl.push_back(mk(mk_in(0, 0, 0, 1, 1, 32'h500, 32'hAAAA, 4'hF, 0, 32'h0), 1, 32'h0, 0));
    tbl.push_back(mk(rst_v, 1, 32'h0, 1));
    tbl.push_back(mk(mk_in(0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h99999999), 0, 32'h0, 0));
    tbl.push_back(mk(idle_v, 0, 32'h0, 0));

    // Initial reset, unchecked since state is undefined before the first edge
    for (int k = 0; k < 2; k++) begin
      drive(rst_v, 0, 6'h0);
      advance(rst_v);
    end

    foreach (tbl[n]) begin
      drive(tbl[n].i, 1, 6'h0);
      chk($sformatf("t%0d_stallreq", n), 32'(stallreq_o), 32'(tbl[n].e_stall));
      chk($sformatf("t%0d_cpu_data", n), cpu_data_o, tbl[n].e_data);
      chk($sformatf("t%0d_cyc", n), 32'(wb_bus.wb_cyc_o), 32'(tbl[n].e_cyc));
      if (n >= 5 && n <= 8) begin
        chk($sformatf("t%0d_sel", n), 32'(wb_bus.wb_sel_o), 32'h3);
        chk($sformatf("t%0d_we", n), 32'(wb_bus.wb_we_o), 32'h1);
      end
      advance(tbl[n].i);
    end

`ifdef DMEM_WB_TIMEOUT_EN
    begin
      in_t ld;
      in_t hold_v;
      ld     = mk_in(0, 0, 0, 1, 0, 32'h600, 32'h0, 4'hF, 0, 32'h0);
      hold_v = mk_in(0, 0, 0, 1, 0, 32'h600, 32'h0, 4'hF, 0, 32'h0);
      drive(ld, 1, 6'h0);
      chk("to_issue_stall", 32'(stallreq_o), 32'h1);
      advance(ld);
      for (int k = 1; k <= TO; k++) begin
        drive(hold_v, 1, 6'h0);
        chk($sformatf("to_busy%0d_cyc", k), 32'(wb_bus.wb_cyc_o), 32'h1);
        chk($sformatf("to_busy%0d_stall", k), 32'(stallreq_o), (k == TO) ? 32'h0 : 32'h1);
        chk($sformatf("to_busy%0d_data", k), cpu_data_o, 32'h0);
        chk($sformatf("to_busy%0d_err", k), 32'(bus_err_o), 32'h0);
        advance(hold_v);
      end
      drive(idle_v, 1, 6'h0);
      chk("to_abort_cyc", 32'(wb_bus.wb_cyc_o), 32'h0);
      chk("to_abort_err", 32'(bus_err_o), 32'h1);
      advance(idle_v);
      drive(idle_v, 1, 6'h0);
      chk("to_err_pulse_end", 32'(bus_err_o), 32'h0);
      advance(idle_v);
    end
`endif

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      in_t        v;
      logic [5:0] oth;
      v.rst   = ($urandom_range(199) == 0);
      v.st4   = ($urandom_range(99) < 30);
      v.flush = ($urandom_range(19) == 0);
      v.ce    = ($urandom_range(99) < 60);
      v.we    = $urandom_range(1) == 1;
      v.addr  = $urandom;
      v.wdat  = $urandom;
      v.sel   = 4'($urandom_range(15));
      v.ack   = ($urandom_range(99) < 40);
      v.rdat  = $urandom;
      oth     = 6'($urandom_range(63));
      drive(v, 1, oth);
      advance(v);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
